hs_upload_arbiter: RTL

- Shares the single HPS upload channel (ioctl_upload_req / ioctl_upload / ioctl_din) between NREQ save requesters (hiscore buffer, NVRAM buffer, ...).
- Latches one-cycle save request pulses, grants the channel round-robin and raises ioctl_upload_req for the winner.
- Tracks the HPS transfer to completion and steers ioctl_din from the granted requester.
- Sits between the requester modules and hps_io in the arcade core top level.

---
 rtl/hs_pkg.sv | 27 ++
 rtl/hs_rr_pick.sv | 39 +++
 rtl/hs_upload_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the hiscore/NVRAM upload arbiter:
//   - hs_state_t : 3-bit FSM state encoding
//   - HS_INDEX_BASE : default ioctl_index of requester 0
//   - HS_CNT_W   : width of the shared saturating cycle counter
//   - hs_sat_inc : saturating increment helper
// ---------------------------------------------------------------------------
package hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_COOLDOWN   = 3'd4
    } hs_state_t;

    localparam int HS_INDEX_BASE = 4;
    localparam int HS_CNT_W      = 32;

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [HS_CNT_W-1:0] hs_sat_inc(input logic [HS_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// ---------------------------------------------------------------------------
// hs_rr_pick
// Combinational round-robin selector. The search starts at rr+1 (mod NREQ)
// and takes the first pending requester found.
// Ports:
//   pending in  NREQ   requesters waiting for the channel
//   rr      in  IDX_W  index of the previous winner
//   winner  out IDX_W  selected requester (0 when valid is low)
//   valid   out 1      at least one requester is pending
// ---------------------------------------------------------------------------
module hs_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] rr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // Walk from the farthest candidate to the nearest; the nearest match
        // (k = 1, i.e. rr+1) is assigned last and therefore wins.
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr) + k) % NREQ;
            if (pending[idx]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_upload_arbiter.sv
// ---------------------------------------------------------------------------
// hs_upload_arbiter
// Shares the single HPS upload channel between NREQ save requesters.
// Save request pulses are latched, the channel is granted round-robin,
// ioctl_upload_req is raised for the winner, and the HPS transfer is tracked
// to completion while ioctl_din is steered from the granted requester.
//
// Ports:
//   clk              in   core clock
//   reset_n          in   asynchronous active-low reset
//   req              in   [NREQ]   save request per requester (pulse or level)
//   req_din          in   [8*NREQ] read data; requester i on [8i+7:8i]
//   grant            out  [NREQ]   one-hot, grant until transfer end
//   done             out  [NREQ]   one-cycle completion pulse
//   ioctl_upload_req out  upload request to hps_io
//   ioctl_upload     in   upload active from hps_io
//   ioctl_index      in   [8] upload index from hps_io
//   ioctl_din        out  [8] upload data to hps_io
//   busy             out  high whenever the FSM is not IDLE
//   timeout_err      out  sticky start timeout flag
//
// Build option: define HS_ARB_TIMEOUT_EN to abandon a grant when HPS does not
// start the upload within TIMEOUT cycles. Without it WAIT_START waits forever
// and timeout_err is constant 0.
// ---------------------------------------------------------------------------
module hs_upload_arbiter
    import hs_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int INDEX_BASE = HS_INDEX_BASE,
    parameter int REQ_HOLD   = 4,
    parameter int GAP        = 16,
    parameter int TIMEOUT    = 2**24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_din,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              ioctl_upload_req,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              busy,
    output logic              timeout_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Terminal counts: a state is left on the cycle the counter shows N-1.
    localparam logic [HS_CNT_W-1:0] HOLD_M1 = (REQ_HOLD > 0) ? HS_CNT_W'(REQ_HOLD - 1) : '0;
    localparam logic [HS_CNT_W-1:0] GAP_M1  = (GAP > 0)      ? HS_CNT_W'(GAP - 1)      : '0;

    hs_state_t             state;
    hs_state_t             state_next;
    logic [NREQ-1:0]       pending;
    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      rr;
    logic                  rr_primed;
    logic [HS_CNT_W-1:0]   cnt;

    logic [IDX_W-1:0]      pick_winner;
    logic                  pick_valid;
    logic [IDX_W-1:0]      rr_eff;
    logic                  grant_fire;
    logic [NREQ-1:0]       grant_mask;
    logic [NREQ-1:0]       winner_onehot;
    logic                  start_hit;
    logic                  upload_end;
    logic                  timeout_hit;

    // Before the first grant the search must start at requester 0, so the
    // pointer is presented as NREQ-1 until one grant has happened.
    assign rr_eff = rr_primed ? rr : IDX_W'(NREQ - 1);

    hs_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending),
        .rr      (rr_eff),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    assign grant_fire = (state == ST_IDLE) && pick_valid;
    assign start_hit  = ioctl_upload && (ioctl_index == 8'(INDEX_BASE + int'(winner)));
    assign upload_end = (state == ST_ACTIVE) && !ioctl_upload;

`ifdef HS_ARB_TIMEOUT_EN
    localparam logic [HS_CNT_W-1:0] TO_M1 = (TIMEOUT > 0) ? HS_CNT_W'(TIMEOUT - 1) : '0;
    // A start on the last allowed cycle still wins over the timeout.
    assign timeout_hit = (state == ST_WAIT_START) && !start_hit && (cnt >= TO_M1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        winner_onehot = '0;
        grant_mask    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDX_W'(i))      winner_onehot[i] = 1'b1;
            if (pick_winner == IDX_W'(i)) grant_mask[i]    = grant_fire;
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:       if (pick_valid)     state_next = ST_REQ;
            ST_REQ:        if (cnt >= HOLD_M1) state_next = ST_WAIT_START;
            ST_WAIT_START: begin
                if (start_hit)        state_next = ST_ACTIVE;
                else if (timeout_hit) state_next = ST_COOLDOWN;
            end
            ST_ACTIVE:     if (!ioctl_upload)  state_next = ST_COOLDOWN;
            ST_COOLDOWN:   if (cnt >= GAP_M1)  state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        grant            = '0;
        ioctl_upload_req = 1'b0;
        busy             = (state != ST_IDLE);
        if (state == ST_REQ) ioctl_upload_req = 1'b1;
        if (state == ST_REQ || state == ST_WAIT_START || state == ST_ACTIVE)
            grant = winner_onehot;
    end

    // Data mux stays combinational so hps_io sees read data with no extra lag.
    always_comb begin
        ioctl_din = 8'h00;
        if (grant != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (winner == IDX_W'(i)) ioctl_din = req_din[8*i +: 8];
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            winner    <= '0;
            rr        <= '0;
            rr_primed <= 1'b0;
            cnt       <= '0;
            done      <= '0;
        end else begin
            // A new req always sets its bit, even on the grant cycle, so a
            // save raised during its own transfer is queued behind it.
            pending <= (pending & ~grant_mask) | req;
            if (grant_fire) begin
                winner    <= pick_winner;
                rr        <= pick_winner;
                rr_primed <= 1'b1;
            end
            // One counter serves REQ hold, start timeout and cooldown; it
            // restarts on every state change.
            cnt  <= (state_next != state) ? '0 : hs_sat_inc(cnt);
            done <= upload_end ? winner_onehot : '0;
        end
    end

`ifdef HS_ARB_TIMEOUT_EN
    logic timeout_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         timeout_q <= 1'b0;
        else if (grant_fire)  timeout_q <= 1'b0;
        else if (timeout_hit) timeout_q <= 1'b1;
    end
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
